seq_mult_wrapper: RTL and testbench
===================================

// Module: seq_mult_wrapper
// PURPOSE
//  Board-level top for an 8x8 signed sequential (shift-add) multiplier with a 4-digit 7-segment readout.
//  BTNC starts a multiply of the switch operands; the 16-bit product is registered and displayed as sign plus decimal digits.
//  BTNL/BTNR scroll a 3-digit window across the 5-digit magnitude.
// PARAMETERS
//  REFRESH_DIV      100_000  clk cycles per display digit slot (multiplex rate)
//  DEBOUNCE_CYCLES  1_000_000  stable cycles required per button (used only with BTN_DEBOUNCE_EN)
// PORTS
//  clk           in   1     system clock, 100 MHz; all state on rising edge
//  rst           in   1     asynchronous, active-low reset
//  en            in   1     global enable; 0 = FSM frozen, display blanked
//  clr           in   1     synchronous clear of product/FSM/scroll
//  BTNC          in   1     start multiply (rising edge)
//  BTNL          in   1     scroll window one digit toward MSD (rising edge)
//  BTNR          in   1     scroll window one digit toward LSD (rising edge)
//  multiplicand  in   8     signed two's-complement operand A
//  multiplier    in   8     signed two's-complement operand B
//  seg           out  [0:6] segments a..g, active-low
//  an            out  4     digit anodes, active-low; an[3] leftmost
//  product       out  16    registered signed product A*B
// BEHAVIOUR
//  Reset (rst=0): product=0, FSM=IDLE, scroll=0, an=4'b1111, seg=7'b1111111.
//  Priority: rst > clr > en=0 > normal. clr: product=0, FSM->IDLE, scroll=0, in-flight op aborted.
//  en=0: FSM and counters hold state; button edges ignored; an=4'b1111.
//  Buttons: 1-stage edge detect; a 1-cycle high pulse is one event.
//  FSM IDLE -> LOAD on BTNC edge: latch |A|,|B|, sign=A[7]^B[7], acc=0, cnt=0.
//  LOAD -> RUN: 8 cycles; if mplier[0] acc+=mcand<<cnt; mplier>>=1; cnt++.
//  RUN (cnt==8) -> DONE: product = sign ? -acc : acc; DONE -> IDLE next cycle.
//  Latency: product valid <=10 cycles after BTNC edge cycle; product holds until next DONE/clr/reset.
//  BTNC during LOAD/RUN/DONE ignored; operand changes mid-op have no effect.
//  Width: |A|,|B| up to 128 -> 128*128=16384 fits; -128*-128 = +16384, -128*127 = -16256.
//  Display: magnitude -> 5 BCD digits; scroll s in 0..2; an[2:0] show digits [s+2:s].
//  an[3]: '-' (seg g only) if product<0, else blank. BTNL: s++ saturating at 2; BTNR: s-- saturating at 0.
//  Mux: one anode low at a time, round-robin, REFRESH_DIV cycles each; blank digit = all segments off.
// CONFIGURATION
//  BTN_DEBOUNCE_EN defined: each button sync'd (2 FF) + counter debounce of DEBOUNCE_CYCLES before edge detect;
//    start latency grows by DEBOUNCE_CYCLES+2.
//  Undefined: raw buttons edge-detected directly (10-cycle latency above).
// STRUCTURE
//  Package seq_mult_pkg: FSM enum {IDLE,LOAD,RUN,DONE}, 7-seg codes for 0-9, minus, blank.
//  Sub-module bin2bcd (16-bit -> 5x4-bit BCD, combinational double-dabble).
//  Top: edge detect, multiplier FSM/datapath, scroll register, refresh divider, digit mux.
// TESTING
//  Reset, A=13,B=7, 1-cycle BTNC -> product=91 within 10 cycles; an[2:0] show 0,9,1.
//  A=4,B=15, BTNC -> product=60; previous 91 held until DONE.
//  A=-128,B=-128 -> 16384; A=-3,B=5 -> 16'hFFF1 (-15), an[3] shows '-'.
//  BTNC again mid-RUN -> ignored; clr mid-RUN -> product=0, FSM IDLE next cycle.
//  BTNL x3 -> scroll=2 (saturates); BTNR x3 -> scroll=0.
//  en=0 during RUN -> product unchanged, an=1111; en=1 -> completes with correct value.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and 7-segment codes for the sequential multiplier board top.
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Segment vectors are ordered a..g (index 0 = a) and active-low.
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  function automatic logic [0:6] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] abs8(input logic [7:0] v);
    // -128 maps to 8'h80, which is correct when read as unsigned 128.
    abs8 = v[7] ? 8'(-v) : v;
  endfunction

endpackage

// File: rtl/seq_mult_wrapper_bin2bcd.sv
// 16-bit binary to 5-digit BCD, combinational double-dabble.
module bin2bcd (
  input  logic [15:0]      bin,
  output logic [4:0][3:0]  bcd
);

  // Shift-and-add-3: correct each digit before every shift so it never exceeds 9.
  always_comb begin
    logic [19:0] sh;
    sh = '0;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 5; d++)
        if (sh[d*4 +: 4] >= 4'd5) sh[d*4 +: 4] = sh[d*4 +: 4] + 4'd3;
      sh = {sh[18:0], bin[i]};
    end
    bcd = sh;
  end

endmodule

// File: rtl/seq_mult_wrapper.sv
// Board top: 8x8 signed shift-add multiplier with scrolling 7-segment readout.
// Optional feature macro: BTN_DEBOUNCE_EN (2-FF sync + counter debounce on buttons).
module seq_mult_wrapper
  import seq_mult_pkg::*;
#(
  parameter int REFRESH_DIV     = 100_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        BTNC,
  input  logic        BTNL,
  input  logic        BTNR,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [0:6]  seg,
  output logic [3:0]  an,
  output logic [15:0] product
);

  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

  // Button bit order: [2]=BTNL, [1]=BTNR, [0]=BTNC
  logic [2:0] btn_raw, btn_clean, btn_q, btn_edge;
  assign btn_raw = {BTNL, BTNR, BTNC};

`ifdef BTN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [1:0]      sync;
    logic [DB_W-1:0] cnt;
    logic            stable;
    // Synchronise, then accept a new level only after it has held long enough.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync <= '0; cnt <= '0; stable <= 1'b0;
      end else begin
        sync <= {sync[0], btn_raw[i]};
        if (sync[1] == stable) cnt <= '0;
        else if (cnt == DB_MAX) begin
          stable <= sync[1];
          cnt    <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
    assign btn_clean[i] = stable;
  end
`else
  assign btn_clean = btn_raw;
`endif

  // Previous button level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= '0;
    else      btn_q <= btn_clean;
  end
  assign btn_edge = btn_clean & ~btn_q;

  state_t      state;
  logic [15:0] mcand, acc, acc_next;
  logic [7:0]  mplier;
  logic [3:0]  cnt;
  logic        sign;

  assign acc_next = acc + (mplier[0] ? (mcand << cnt) : 16'd0);

  // Multiplier FSM and datapath. The product is written on the eighth RUN
  // step (cnt 7 -> 8) so it is already valid while the FSM sits in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; product <= '0; mcand <= '0; mplier <= '0;
      acc <= '0; cnt <= '0; sign <= 1'b0;
    end else if (clr) begin
      state <= IDLE; product <= '0; cnt <= '0;
    end else if (en) begin
      case (state)
        IDLE: if (btn_edge[0]) begin
          mcand  <= {8'h00, abs8(multiplicand)};
          mplier <= abs8(multiplier);
          sign   <= multiplicand[7] ^ multiplier[7];
          acc    <= '0;
          cnt    <= '0;
          state  <= LOAD;
        end
        LOAD: state <= RUN;
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            product <= sign ? 16'(-acc_next) : acc_next;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [1:0] scroll;

  // Scroll window position, saturating at 0 and 2; BTNL wins over BTNR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       scroll <= '0;
    else if (clr)   scroll <= '0;
    else if (en) begin
      if (btn_edge[2] && scroll != 2'd2)      scroll <= scroll + 2'd1;
      else if (btn_edge[1] && scroll != 2'd0) scroll <= scroll - 2'd1;
    end
  end

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    slot;

  // Refresh divider: advance the active digit slot every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0; slot <= '0;
    end else if (en) begin
      if (refresh_cnt == REFRESH_MAX) begin
        refresh_cnt <= '0;
        slot        <= slot + 2'd1;
      end else refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  logic [15:0]     mag;
  logic [4:0][3:0] digits;
  logic [2:0]      idx;
  logic [0:6]      seg_next;

  assign mag = product[15] ? 16'(-product) : product;
  assign idx = {1'b0, scroll} + {1'b0, slot};

  bin2bcd u_bcd (.bin(mag), .bcd(digits));

  // Slot 3 is the sign position; slots 0..2 show digits scroll..scroll+2.
  always_comb begin
    seg_next = SEG_BLANK;
    if (slot == 2'd3) seg_next = product[15] ? SEG_MINUS : SEG_BLANK;
    else              seg_next = seg_code(digits[idx]);
  end

  // Registered display drive; disabled block shows nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an <= 4'b1111; seg <= SEG_BLANK;
    end else if (!en) begin
      an <= 4'b1111; seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << slot);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seq_mult_wrapper.sv
// Scoreboard bench for seq_mult_wrapper: expected products are queued at
// start, a monitor pops one each time the FSM presents DONE.
module tb_seq_mult_wrapper;
  import seq_mult_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b1, clr = 1'b0;
  logic        BTNC = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
  logic [7:0]  multiplicand = '0, multiplier = '0;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] product;

  int n_checks = 0, n_fail = 0;
  logic [15:0] sb[$];

  localparam logic [0:6] S_BLANK = 7'b1111111, S_MINUS = 7'b1111110;
  localparam logic [0:6] S0 = 7'b0000001, S1 = 7'b1001111, S3 = 7'b0000110;
  localparam logic [0:6] S4 = 7'b1001100, S6 = 7'b0100000, S8 = 7'b0000000;
  localparam logic [0:6] S9 = 7'b0000100, S5 = 7'b0100100;

  seq_mult_wrapper #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .BTNC(BTNC), .BTNL(BTNL),
    .BTNR(BTNR), .multiplicand(multiplicand), .multiplier(multiplier),
    .seg(seg), .an(an), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: DONE lasts one cycle and marks the product as freshly valid.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && dut.state == DONE) begin
        if (sb.size() == 0) check("unexpected_done", 32'(product), 32'hFFFF_FFFF);
        else check("product", 32'(product), 32'(sb.pop_front()));
      end
    end
  end

  task automatic pulse(input int which);
    @(negedge clk);
    case (which) 0: BTNC = 1'b1; 1: BTNL = 1'b1; default: BTNR = 1'b1; endcase
    @(negedge clk);
    BTNC = 1'b0; BTNL = 1'b0; BTNR = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    multiplicand = a; multiplier = b;
    sb.push_back(exp);
    pulse(0);
  endtask

  // Returns negedges elapsed after the pulse released until DONE; 99 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dut.state == DONE) begin cyc = i; break; end
    end
    if (cyc == 99) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture(output logic [0:6] d0, d1, d2, d3);
    d0 = 7'b0101010; d1 = 7'b0101010; d2 = 7'b0101010; d3 = 7'b0101010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: d0 = seg;
        4'b1101: d1 = seg;
        4'b1011: d2 = seg;
        4'b0111: d3 = seg;
        default: ;
      endcase
    end
  endtask

  initial begin
    int cyc;
    logic [0:6] d0, d1, d2, d3;

    repeat (3) @(negedge clk);
    check("rst_product", 32'(product), 32'd0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(S_BLANK));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 13*7 = 91, latency bound, digits 0 9 1 with blank sign
    start_op(8'd13, 8'd7, 16'd91);
    wait_done(cyc);
    check("latency", 32'(cyc + 1 <= 10), 32'd1);
    capture(d0, d1, d2, d3);
    check("disp91_d0", 32'(d0), 32'(S1));
    check("disp91_d1", 32'(d1), 32'(S9));
    check("disp91_d2", 32'(d2), 32'(S0));
    check("disp91_sign", 32'(d3), 32'(S_BLANK));

    // 4*15 = 60; old product held mid-operation
    start_op(8'd4, 8'd15, 16'd60);
    repeat (4) @(negedge clk);
    check("hold_91", 32'(product), 32'd91);
    wait_done(cyc);

    start_op(8'h80, 8'h7F, 16'hC080);   // -128*127 = -16256
    wait_done(cyc);
    start_op(8'hFD, 8'd5, 16'hFFF1);    // -3*5 = -15
    wait_done(cyc);
    capture(d0, d1, d2, d3);
    check("disp_m15_d0", 32'(d0), 32'(S5));
    check("disp_m15_d1", 32'(d1), 32'(S1));
    check("disp_m15_sign", 32'(d3), 32'(S_MINUS));

    // -128*-128 = 16384 (digits 1 6 3 8 4), then scroll
    start_op(8'h80, 8'h80, 16'd16384);
    wait_done(cyc);
    repeat (3) begin pulse(1); @(negedge clk); end
    check("scroll_sat2", 32'(dut.scroll), 32'd2);
    capture(d0, d1, d2, d3);
    check("s2_d0", 32'(d0), 32'(S3));
    check("s2_d1", 32'(d1), 32'(S6));
    check("s2_d2", 32'(d2), 32'(S1));
    pulse(2); @(negedge clk);
    capture(d0, d1, d2, d3);
    check("s1_d0", 32'(d0), 32'(S8));
    check("s1_d2", 32'(d2), 32'(S6));
    repeat (2) begin pulse(2); @(negedge clk); end
    capture(d0, d1, d2, d3);
    check("s0_d0", 32'(d0), 32'(S4));
    check("s0_d1", 32'(d1), 32'(S8));
    check("s0_d2", 32'(d2), 32'(S3));

    // BTNC and operand changes mid-RUN ignored: 25*-4 = -100
    start_op(8'd25, 8'hFC, 16'hFF9C);
    repeat (3) @(negedge clk);
    multiplicand = 8'd1; multiplier = 8'd1;
    pulse(0);
    wait_done(cyc);
    repeat (12) @(negedge clk);

    // clr mid-RUN aborts and clears
    multiplicand = 8'd9; multiplier = 8'd9;
    pulse(0);
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_product", 32'(product), 32'd0);
    check("clr_state", 32'(dut.state), 32'(IDLE));
    repeat (12) @(negedge clk);
    check("clr_stays", 32'(product), 32'd0);

    // en=0 freezes mid-RUN; resume completes -7*-11 = 77
    start_op(8'hF9, 8'hF5, 16'd77);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("en0_an", 32'(an), 32'hF);
    check("en0_product", 32'(product), 32'd0);
    check("en0_state", 32'(dut.state), 32'(RUN));
    en = 1'b1;
    wait_done(cyc);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
